uart_rx_fsm: RTL

UART_RX_FSM -- requirements
Module: uart_rx_fsm

---
 rtl/uart_rx_fsm.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fsm.sv
// UART receive controller: oversampled start/data/parity/stop framing with registered strobes.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around mid-bit.
module uart_rx_fsm #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX_IN,
    input  logic [5:0]        Prescale,
    input  logic              PAR_EN,
    input  logic              Par_err,
    output logic              sampled_bit,
    output logic              new_bit,
    output logic              par_chk_en,
    output logic [DATA_W-1:0] P_DATA,
    output logic              data_valid,
    output logic              strt_glitch,
    output logic              stop_err,
    output logic              par_err_flg
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state_reg, state_next;
    logic [5:0]        edge_cnt_reg, edge_cnt_next;
    logic [5:0]        prescale_reg, prescale_next;
    logic [BW-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              mid_reg, mid_next;
`ifdef UART_RX_MAJORITY_EN
    logic              early_reg, early_next;
`endif
    logic              sampled_reg, sampled_next;
    logic              perr_reg, perr_next;
    logic              new_bit_reg, new_bit_next;
    logic              par_chk_reg, par_chk_next;
    logic              valid_reg, valid_next;
    logic              glitch_reg, glitch_next;
    logic              stop_err_reg, stop_err_next;
    logic              par_err_reg, par_err_next;
    logic              shift_load;
    logic [5:0]        half;
    logic              last;

    // Timing is always taken from the value latched at start-bit detection.
    assign half = {1'b0, prescale_reg[5:1]};
    assign last = (edge_cnt_reg == prescale_reg - 6'd1);

    always_comb begin
        state_next    = state_reg;
        edge_cnt_next = edge_cnt_reg;
        prescale_next = prescale_reg;
        bit_cnt_next  = bit_cnt_reg;
        data_next     = data_reg;
        mid_next      = mid_reg;
`ifdef UART_RX_MAJORITY_EN
        early_next    = early_reg;
`endif
        sampled_next  = sampled_reg;
        perr_next     = perr_reg;
        new_bit_next  = 1'b0;
        par_chk_next  = 1'b0;
        valid_next    = 1'b0;
        glitch_next   = 1'b0;
        stop_err_next = 1'b0;
        par_err_next  = 1'b0;
        shift_load    = 1'b0;

        if (state_reg != IDLE) begin
            edge_cnt_next = last ? 6'd0 : edge_cnt_reg + 6'd1;
`ifdef UART_RX_MAJORITY_EN
            if (edge_cnt_reg == half - 6'd1)
                early_next = RX_IN;
            if (edge_cnt_reg == half)
                mid_next = RX_IN;
            if (edge_cnt_reg == half + 6'd1)
                sampled_next = (early_reg & mid_reg) | (early_reg & RX_IN) | (mid_reg & RX_IN);
`else
            if (edge_cnt_reg == half)
                mid_next = RX_IN;
            if (edge_cnt_reg == half + 6'd1)
                sampled_next = mid_reg;
`endif
        end

        case (state_reg)
            IDLE: begin
                if (!RX_IN) begin
                    state_next    = START;
                    edge_cnt_next = 6'd0;
                    prescale_next = Prescale;
                    perr_next     = 1'b0;
                end
            end
            START: begin
                if (last) begin
                    if (sampled_reg) begin
                        glitch_next = 1'b1;
                        state_next  = IDLE;
                    end else begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end
                end
            end
            DATA: begin
                if (last) begin
                    new_bit_next = 1'b1;
                    shift_load   = 1'b1;
                    if (bit_cnt_reg == LAST_BIT) begin
                        bit_cnt_next = '0;
                        state_next   = PAR_EN ? PARITY : STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (last) begin
                    par_chk_next = 1'b1;
                    state_next   = STOP;
                end
            end
            STOP: begin
                if (edge_cnt_reg == 6'd0)
                    perr_next = PAR_EN & Par_err;
                if (last) begin
                    stop_err_next = ~sampled_reg;
                    par_err_next  = perr_reg;
                    if (sampled_reg && !perr_reg) begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                    end
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_shift
        localparam logic [BW-1:0] IDX = BW'(gi);
        assign shift_next[gi] = (shift_load && bit_cnt_reg == IDX) ? sampled_reg : shift_reg[gi];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg    <= IDLE;
            edge_cnt_reg <= '0;
            prescale_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            data_reg     <= '0;
            mid_reg      <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
            early_reg    <= 1'b1;
`endif
            sampled_reg  <= 1'b1;
            perr_reg     <= 1'b0;
            new_bit_reg  <= 1'b0;
            par_chk_reg  <= 1'b0;
            valid_reg    <= 1'b0;
            glitch_reg   <= 1'b0;
            stop_err_reg <= 1'b0;
            par_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            edge_cnt_reg <= edge_cnt_next;
            prescale_reg <= prescale_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            data_reg     <= data_next;
            mid_reg      <= mid_next;
`ifdef UART_RX_MAJORITY_EN
            early_reg    <= early_next;
`endif
            sampled_reg  <= sampled_next;
            perr_reg     <= perr_next;
            new_bit_reg  <= new_bit_next;
            par_chk_reg  <= par_chk_next;
            valid_reg    <= valid_next;
            glitch_reg   <= glitch_next;
            stop_err_reg <= stop_err_next;
            par_err_reg  <= par_err_next;
        end
    end

    assign sampled_bit = sampled_reg;
    assign new_bit     = new_bit_reg;
    assign par_chk_en  = par_chk_reg;
    assign P_DATA      = data_reg;
    assign data_valid  = valid_reg;
    assign strt_glitch = glitch_reg;
    assign stop_err    = stop_err_reg;
    assign par_err_flg = par_err_reg;

endmodule
